ecall_halt_unit: RTL

//   Consumer end of the ecall x17 forwarding path in the 5-stage pipeline. Takes the forwarded
//   x17 value for an ecall in ID, decides halt, freezes fetch, drains older instructions

---
 rtl/ecall_halt_unit_if.sv | 28 ++
 rtl/ecall_halt_unit.sv | 119 +++++++++++
 2 files changed

// File: rtl/ecall_halt_unit_if.sv
// ecall_halt_unit_if: the ID-stage signals seen by the ecall halt unit and the
// pipeline controls it returns.
// master = pipeline/hazard side, slave = ecall_halt_unit.
interface ecall_halt_unit_if #(
  parameter int XLEN = 32
);
  logic            ID_valid;
  logic            is_ecall;
  logic            stall;
  logic [XLEN-1:0] x17_fwd;
  logic [XLEN-1:0] ID_pc;
  logic            pc_write_disable;
  logic            IF_ID_flush;
  logic            ID_EX_bubble;
  logic            halt_pending;
  logic            is_halted;
  logic [XLEN-1:0] halt_pc;

  modport master (
    output ID_valid, is_ecall, stall, x17_fwd, ID_pc,
    input  pc_write_disable, IF_ID_flush, ID_EX_bubble, halt_pending, is_halted, halt_pc
  );

  modport slave (
    input  ID_valid, is_ecall, stall, x17_fwd, ID_pc,
    output pc_write_disable, IF_ID_flush, ID_EX_bubble, halt_pending, is_halted, halt_pc
  );
endinterface

// File: rtl/ecall_halt_unit.sv
// ecall_halt_unit: accepts a halting ecall (x17 == HALT_CODE) in ID, freezes
// fetch, lets older instructions drain for DRAIN_CYCLES cycles, then holds a
// sticky is_halted until reset.
// Optional feature macro: HALT_SNAPSHOT_EN (captures the halting ecall's PC
// into halt_pc; without it halt_pc is constant 0 and ID_pc is unused).
module ecall_halt_unit #(
  parameter int XLEN         = 32,
  parameter int HALT_CODE    = 10,
  parameter int DRAIN_CYCLES = 3
) (
  input logic              clk,
  input logic              reset,   // synchronous, active-low
  ecall_halt_unit_if.slave bus
);

  localparam int CW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_next;
  logic            w_accept;
  logic            w_pc_write_disable;
  logic            w_if_id_flush;
  logic            w_id_ex_bubble;
  logic            w_halt_pending;
  logic            w_is_halted;

  // A stalled ecall is ignored this cycle; it is re-evaluated once the hazard
  // unit releases ID and forwarding has delivered the final x17 value.
  assign w_accept = (r_state == ST_RUN) & bus.ID_valid & bus.is_ecall & ~bus.stall &
                    (bus.x17_fwd == XLEN'(HALT_CODE));

  // State and drain-counter registers; reset overrides a same-cycle accept.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic and pipeline controls.
  always_comb begin
    w_state_next       = r_state;
    w_cnt_next         = r_cnt;
    w_pc_write_disable = 1'b0;
    w_if_id_flush      = 1'b0;
    w_id_ex_bubble     = 1'b0;
    w_halt_pending     = 1'b0;
    w_is_halted        = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_accept) begin
          // The ecall itself moves on to EX, so no bubble this cycle.
          w_state_next       = ST_DRAIN;
          w_cnt_next         = CW'(DRAIN_CYCLES);
          w_pc_write_disable = 1'b1;
          w_if_id_flush      = 1'b1;
        end
      end
      ST_DRAIN: begin
        w_cnt_next         = r_cnt - CW'(1);
        w_pc_write_disable = 1'b1;
        w_if_id_flush      = 1'b1;
        w_id_ex_bubble     = 1'b1;
        w_halt_pending     = 1'b1;
        if (r_cnt == CW'(1)) begin
          w_state_next = ST_HALTED;
        end
      end
      ST_HALTED: begin
        w_pc_write_disable = 1'b1;
        w_if_id_flush      = 1'b1;
        w_id_ex_bubble     = 1'b1;
        w_is_halted        = 1'b1;
      end
      default: begin
        w_state_next = ST_RUN;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign bus.pc_write_disable = w_pc_write_disable;
  assign bus.IF_ID_flush      = w_if_id_flush;
  assign bus.ID_EX_bubble     = w_id_ex_bubble;
  assign bus.halt_pending     = w_halt_pending;
  assign bus.is_halted        = w_is_halted;

`ifdef HALT_SNAPSHOT_EN
  logic [XLEN-1:0] r_halt_pc;

  // Snapshot the PC of the accepted ecall; held through DRAIN and HALTED.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_halt_pc <= '0;
    end else if (w_accept) begin
      r_halt_pc <= bus.ID_pc;
    end
  end

  assign bus.halt_pc = r_halt_pc;
`else
  logic w_unused_id_pc;

  assign w_unused_id_pc = ^bus.ID_pc;
  assign bus.halt_pc    = '0;
`endif

endmodule
